// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operand width,
// divider iteration count, op encoding, controller states, divide context.
package muldiv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Everything the FIX cycle needs besides the magnitude quotient/remainder.
    typedef struct packed {
        logic            a_neg;
        logic            q_neg;
        logic            zero;
        logic [XLEN-1:0] raw_a;
    } div_ctx_t;

    // Absolute value when signed; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                  input logic            is_signed);
        return (is_signed && x[XLEN-1]) ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring radix-2 division step on unsigned magnitudes.
// Ports:
//   rem     - partial remainder before the step
//   quo     - dividend/quotient shift register before the step
//   divisor - divisor magnitude
//   rem_c   - partial remainder after the step (combinational)
//   quo_c   - quotient register after the step, new bit shifted in at LSB
module div_radix2_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_c,
    output logic [XLEN-1:0] quo_c
);

    logic [XLEN:0] shifted;
    logic          fits;

    // Bring the next dividend bit into the remainder; extra bit avoids overflow.
    assign shifted = {rem, quo[XLEN-1]};
    assign fits    = shifted >= {1'b0, divisor};
    assign rem_c   = fits ? XLEN'(shifted - {1'b0, divisor}) : shifted[XLEN-1:0];
    assign quo_c   = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide controller owning the HI/LO register pair.
// MULT/MULTU take one cycle after accept, DIV/DIVU run 32 restoring steps
// followed by a sign-fixup cycle, MTHI/MTLO write directly from IDLE.
// Optional build macro: MULDIV_FAST_ZERO_EN - a zero divisor skips the
// iteration cycles and goes straight to the fixup cycle.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - request valid from EX
//   op        - operation code (muldiv_pkg::op_e)
//   a, b      - rs / rt operands
//   flush     - cancel any in-flight operation
//   stall     - EX must hold (combinational)
//   done      - pulse in the cycle HI/LO take a mul/div result (combinational)
//   hi, lo    - HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e state, state_next;

    logic [CNT_W-1:0] cnt;

    logic [XLEN-1:0] mul_a, mul_b;
    logic            mul_signed;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;

    logic [XLEN-1:0] div_rem, div_quo, div_dvsr;
    logic [XLEN-1:0] step_rem, step_quo;
    div_ctx_t        div_ctx;

    logic [XLEN-1:0] q_fix, r_fix;
    logic            accept;
    logic            div_is_signed;

    op_e op_dec;
    assign op_dec = op_e'(op);

    // Request is taken only in IDLE and only when not squashed.
    assign accept        = (state == ST_IDLE) && start && !flush;
    assign div_is_signed = (op_dec == OP_DIV);

    div_radix2_step u_step (
        .rem     (div_rem),
        .quo     (div_quo),
        .divisor (div_dvsr),
        .rem_c   (step_rem),
        .quo_c   (step_quo)
    );

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned multiply.
    assign mul_a_ext = {{XLEN{mul_signed & mul_a[XLEN-1]}}, mul_a};
    assign mul_b_ext = {{XLEN{mul_signed & mul_b[XLEN-1]}}, mul_b};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    // Sign fixup: quotient truncates toward zero, remainder follows dividend.
    assign q_fix = div_ctx.q_neg ? XLEN'(-div_quo) : div_quo;
    assign r_fix = div_ctx.a_neg ? XLEN'(-div_rem) : div_rem;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, stall and done.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op_dec)
                        OP_MULT, OP_MULTU: begin
                            state_next = ST_MUL;
                            stall      = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            stall = 1'b1;
`ifdef MULDIV_FAST_ZERO_EN
                            state_next = (b == '0) ? ST_FIX : ST_DIV;
`else
                            state_next = ST_DIV;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_DIV: begin
                stall = 1'b1;
                if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
            done       = 1'b0;
        end
        if (rst) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    // Operand latches, divider iteration, HI/LO writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi         <= '0;
            lo         <= '0;
            cnt        <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            div_rem    <= '0;
            div_quo    <= '0;
            div_dvsr   <= '0;
            div_ctx    <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_dec)
                            OP_MULT, OP_MULTU: begin
                                mul_a      <= a;
                                mul_b      <= b;
                                mul_signed <= (op_dec == OP_MULT);
                            end
                            OP_DIV, OP_DIVU: begin
                                cnt           <= '0;
                                div_rem       <= '0;
                                div_quo       <= magnitude(a, div_is_signed);
                                div_dvsr      <= magnitude(b, div_is_signed);
                                div_ctx.a_neg <= div_is_signed & a[XLEN-1];
                                div_ctx.q_neg <= div_is_signed & (a[XLEN-1] ^ b[XLEN-1]);
                                div_ctx.zero  <= (b == '0);
                                div_ctx.raw_a <= a;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    {hi, lo} <= mul_prod;
                end
                ST_DIV: begin
                    div_rem <= step_rem;
                    div_quo <= step_quo;
                    cnt     <= cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    cnt <= '0;
                    if (div_ctx.zero) begin
                        lo <= '1;
                        hi <= div_ctx.raw_a;
                    end else begin
                        lo <= q_fix;
                        hi <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a cycle-level reference model checked
// every cycle, plus directed operations with hand-computed results.
module tb_muldiv_unit;

    localparam logic [2:0] K_NONE  = 3'd0;
    localparam logic [2:0] K_MULT  = 3'd1;
    localparam logic [2:0] K_MULTU = 3'd2;
    localparam logic [2:0] K_DIV   = 3'd3;
    localparam logic [2:0] K_DIVU  = 3'd4;
    localparam logic [2:0] K_MTHI  = 3'd5;
    localparam logic [2:0] K_MTLO  = 3'd6;

`ifdef MULDIV_FAST_ZERO_EN
    localparam bit FAST_ZERO = 1'b1;
    localparam int ZDIV_DONE = 1;
`else
    localparam bit FAST_ZERO = 1'b0;
    localparam int ZDIV_DONE = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        stall, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [63:0] sx, sy, sq, sr;
        logic [63:0] ux, uy;
        sx = 64'($signed(x));
        sy = 64'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            K_MULT:  return 64'(sx * sy);
            K_MULTU: return ux * uy;
            K_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                sq = sx / sy;
                sr = sx % sy;
                return {sr[31:0], sq[31:0]};
            end
            K_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Reference model: an active op waits m_wait cycles, then writes.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_active = 1'b0;
    int          m_wait = 0;
    logic [63:0] m_res = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_hi     <= 32'd0;
            m_lo     <= 32'd0;
            m_active <= 1'b0;
            m_wait   <= 0;
        end else if (flush) begin
            m_active <= 1'b0;
        end else if (m_active) begin
            if (m_wait == 0) begin
                {m_hi, m_lo} <= m_res;
                m_active     <= 1'b0;
            end else begin
                m_wait <= m_wait - 1;
            end
        end else if (start) begin
            case (op)
                K_MULT, K_MULTU: begin
                    m_active <= 1'b1;
                    m_wait   <= 0;
                    m_res    <= ref_result(op, a, b);
                end
                K_DIV, K_DIVU: begin
                    m_active <= 1'b1;
                    m_wait   <= (FAST_ZERO && b == 32'd0) ? 0 : 32;
                    m_res    <= ref_result(op, a, b);
                end
                K_MTHI: m_hi <= a;
                K_MTLO: m_lo <= a;
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic exp_stall, exp_done;
        exp_stall = !rst && ((!m_active && start && op >= K_MULT && op <= K_DIVU && !flush)
                             || (m_active && m_wait > 0));
        exp_done  = !rst && m_active && m_wait == 0 && !flush;
        chk("model_stall", 64'(stall), 64'(exp_stall));
        chk("model_done",  64'(done),  64'(exp_done));
        chk("model_hi",    64'(hi),    64'(m_hi));
        chk("model_lo",    64'(lo),    64'(m_lo));
    end

    // Issue one mul/div and check done latency, accept-cycle stall, result.
    task automatic run_op(input string nm, input logic [2:0] o,
                          input logic [31:0] va, input logic [31:0] vb,
                          input int exp_cyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int cyc = 0;
        int done_at = -1;
        bit seen = 1'b0;
        logic stall0 = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = va; b = vb;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            if (cyc == 0) stall0 = stall;
            if (done) begin
                seen    = 1'b1;
                done_at = cyc;
            end
            @(posedge clk); #1;
            start = 1'b0; op = K_NONE;
            cyc++;
        end
        chk({nm, "_stall_c0"}, 64'(stall0), 64'd1);
        if (!seen) chk({nm, "_done_timeout"}, 64'd0, 64'd1);
        else       chk({nm, "_done_cycle"}, 64'(done_at), 64'(exp_cyc));
        chk({nm, "_hi"}, 64'(hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        run_op("mult_m3x5",  K_MULT,  32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max",  K_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7d2",   K_DIV,   32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100d7", K_DIVU,  32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("div_ovf",    K_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
        run_op("div_7dm2",   K_DIV,   32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
        run_op("div_zero",   K_DIV,   32'hFFFF_FFFB, 32'd0, ZDIV_DONE, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("divu_zero",  K_DIVU,  32'h0000_1234, 32'd0, ZDIV_DONE, 32'h0000_1234, 32'hFFFF_FFFF);

        // Flush a DIVU at cycle 10: no done, HI/LO keep prior values.
        @(posedge clk); #1;
        start = 1'b1; op = K_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = K_NONE;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_stall_c11", 64'(stall), 64'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("flush_no_done", 64'(seen_done), 64'd0);
        chk("flush_hi", 64'(hi), 64'h1234);
        chk("flush_lo", 64'(lo), 64'hFFFF_FFFF);

        // MTHI then MTLO back-to-back, then squashed moves.
        @(posedge clk); #1;
        start = 1'b1; op = K_MTHI; a = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("mthi_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op = K_MTLO; a = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("mtlo_stall", 64'(stall), 64'd0);
        chk("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
        chk("mthi_lo_kept", 64'(lo), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        op = K_MTHI; a = 32'hDEAD_BEEF; flush = 1'b1;
        @(negedge clk);
        chk("mtlo_lo", 64'(lo), 64'h5A5A_5A5A);
        @(posedge clk); #1;
        op = K_MTLO; a = 32'hCAFE_F00D;
        @(posedge clk); #1;
        start = 1'b0; op = K_NONE; flush = 1'b0;
        chk("mt_flush_hi", 64'(hi), 64'hA5A5_A5A5);
        chk("mt_flush_lo", 64'(lo), 64'h5A5A_5A5A);

        // Reset in the middle of a divide clears HI/LO and stall.
        @(posedge clk); #1;
        start = 1'b1; op = K_DIV; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; op = K_NONE;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        @(negedge clk);
        chk("rst_mid_idle_stall", 64'(stall), 64'd0);

        run_op("divu_after_rst", K_DIVU, 32'hFFFF_FFFF, 32'd16, 33, 32'd15, 32'h0FFF_FFFF);
        run_op("mult_neg_neg",   K_MULT, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
